// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: instruction-cache read port, redirect/stall inputs
// and the fetch-stage outputs feeding the IF/ID register.
interface if_fetch_queue_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_rdata;
    logic        ifid_load;
    logic        ifid_rst;

    modport master (
        output imem_read, imem_address,
        output if_valid, if_pc, if_rdata,
        output ifid_load, ifid_rst,
        input  imem_resp, imem_rdata,
        input  redirect, redirect_pc, ifid_stall
    );

    modport slave (
        input  imem_read, imem_address,
        input  if_valid, if_pc, if_rdata,
        input  ifid_load, ifid_rst,
        output imem_resp, imem_rdata,
        output redirect, redirect_pc, ifid_stall
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC generator, single-outstanding icache read, small
// instruction queue and IF/ID load/bubble control.
module if_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_queue_if.master  fq
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       stale_pc_q, stale_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]       pc_mem_q   [DEPTH];
    logic [31:0]       data_mem_q [DEPTH];

    logic valid;
    logic push;
    logic pop;

    assign valid = (count_q != '0);
    assign push  = (state_q == FETCH) & fq.imem_resp & ~fq.redirect;
    assign pop   = valid & ~fq.ifid_stall & ~fq.redirect;

    assign fq.if_valid  = valid;
    assign fq.if_pc     = pc_mem_q[rd_ptr_q];
    assign fq.if_rdata  = data_mem_q[rd_ptr_q];
    assign fq.ifid_load = pop;
    assign fq.ifid_rst  = fq.redirect | (~valid & ~fq.ifid_stall);

    // Queue occupancy and pointers; a redirect flushes everything.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (fq.redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (!push && pop)
                count_d = count_q - 1'b1;
        end
    end

    // Request FSM: next state, fetch/stale PCs and cache request outputs.
    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        stale_pc_d      = stale_pc_q;
        fq.imem_read    = 1'b0;
        fq.imem_address = fetch_pc_q;
        if (fq.redirect)
            fetch_pc_d = fq.redirect_pc;
        else if (push)
            fetch_pc_d = fetch_pc_q + 32'd4;
        unique case (state_q)
            IDLE: begin
                if (fq.redirect || (count_q < FULL))
                    state_d = FETCH;
            end
            FETCH: begin
                fq.imem_read = 1'b1;
                if (fq.imem_resp) begin
                    if (fq.redirect)
                        state_d = FETCH;
                    else
                        state_d = (count_d < FULL) ? FETCH : IDLE;
                end else if (fq.redirect) begin
                    stale_pc_d = fetch_pc_q;
                    state_d    = DISCARD;
                end
            end
            DISCARD: begin
                fq.imem_read    = 1'b1;
                fq.imem_address = stale_pc_q;
                if (fq.imem_resp)
                    state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            stale_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            stale_pc_q <= stale_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage: write the returned word and its PC at the tail.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            data_mem_q[wr_ptr_q] <= fq.imem_rdata;
        end
    end
endmodule
